// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: PC -> word store read with wait states,
// error flagging, flush and loader port. Ports: req_*, resp_*, load_*, flush, busy.
module imem_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h00400000,
  parameter int          ADDR_W      = 11,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic [31:0]       resp_pc,
  output logic              resp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] pc_q;
  logic err_q;
  logic [31:0] rdata_q;
  logic ready;
  logic accept;

  logic [31:0] mem [2**ADDR_W];

  // Word offset from BASE_ADDR; BASE_ADDR is word aligned, so the
  // byte offset bits never borrow into the word offset.
  logic [29:0] woff;
  logic [ADDR_W-1:0] raddr;
  logic req_err;

  assign woff  = req_pc[31:2] - BASE_ADDR[31:2];
  assign raddr = woff[ADDR_W-1:0];
  assign req_err = (|req_pc[1:0])
                 | (req_pc < BASE_ADDR)
                 | (|woff[29:ADDR_W]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    unique case (state_q)
      S_IDLE: ready = ~flush;
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        ready = resp_ready & ~flush;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    accept = req_valid & ready;
    if (accept) begin
      state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
      cnt_d   = WS;
    end
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pc_q  <= req_pc;
        err_q <= req_err;
      end
    end
  end

  // Read happens at the accept edge, before any same-edge load lands.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (accept) rdata_q <= mem[raddr];
  end

  assign req_ready  = ready;
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_pc    = pc_q;
  assign resp_err   = err_q;
  assign resp_inst  = !resp_valid ? 32'h0
                    : err_q ? NOP_WORD
                    : rdata_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: one instance with one wait
// state, one with zero wait states for the throughput case.
module tb_imem_fetch_responder;

  logic clk = 1'b0;
  logic rst;
  logic load_en;
  logic [10:0] load_addr;
  logic [31:0] load_data;

  logic a_req_valid, a_req_ready, a_flush;
  logic [31:0] a_req_pc;
  logic a_resp_valid, a_resp_ready, a_resp_err, a_busy;
  logic [31:0] a_resp_inst, a_resp_pc;

  logic b_req_valid, b_req_ready, b_flush;
  logic [31:0] b_req_pc;
  logic b_resp_valid, b_resp_ready, b_resp_err, b_busy;
  logic [31:0] b_resp_inst, b_resp_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_responder #(.WAIT_STATES(1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_pc(a_req_pc), .flush(a_flush),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_inst(a_resp_inst), .resp_pc(a_resp_pc),
    .resp_err(a_resp_err),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(a_busy)
  );

  imem_fetch_responder #(.WAIT_STATES(0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_pc(b_req_pc), .flush(b_flush),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_inst(b_resp_inst), .resp_pc(b_resp_pc),
    .resp_err(b_resp_err),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(b_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [10:0] addr,
                      input logic [31:0] data);
    load_en = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic fetch_a(input string tag,
                         input logic [31:0] pc,
                         input logic [31:0] inst,
                         input logic err);
    a_req_pc = pc;
    a_req_valid = 1'b1;
    a_resp_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    #1;
    chk({tag, "_wait_busy"}, a_busy, 1);
    chk({tag, "_wait_vld"}, a_resp_valid, 0);
    tick();
    #1;
    chk({tag, "_vld"}, a_resp_valid, 1);
    chk({tag, "_inst"}, a_resp_inst, inst);
    chk({tag, "_pc"}, a_resp_pc, pc);
    chk({tag, "_err"}, a_resp_err, err);
    tick();
    #1;
    chk({tag, "_done"}, a_resp_valid, 0);
    chk({tag, "_idle"}, a_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    a_req_valid = 1'b0; a_req_pc = '0;
    a_flush = 1'b0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_pc = '0;
    b_flush = 1'b0; b_resp_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_vld", a_resp_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_inst", a_resp_inst, 0);
    chk("rst_pc", a_resp_pc, 0);
    chk("rst_err", a_resp_err, 0);
    chk("rst_rdy", a_req_ready, 1);

    // Store fill while the core is held in reset
    tick();
    load(11'd0, 32'h3C010040);
    load(11'd1, 32'h34210004);
    load(11'd2047, 32'hDEADBEEF);
    rst = 1'b1;
    tick();

    fetch_a("w0", 32'h00400000, 32'h3C010040, 1'b0);
    fetch_a("w1", 32'h00400004, 32'h34210004, 1'b0);
    fetch_a("mis", 32'h00400002, 32'h00000000, 1'b1);
    fetch_a("oor", 32'h00402000, 32'h00000000, 1'b1);
    fetch_a("low", 32'h003FFFFC, 32'h00000000, 1'b1);
    fetch_a("last", 32'h00401FFC, 32'hDEADBEEF, 1'b0);

    // Backpressure in RESP
    a_req_pc = 32'h00400004;
    a_req_valid = 1'b1;
    a_resp_ready = 1'b0;
    tick();
    a_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", a_resp_valid, 1);
      chk("bp_inst", a_resp_inst, 32'h34210004);
      chk("bp_pc", a_resp_pc, 32'h00400004);
      chk("bp_rdy", a_req_ready, 0);
      tick();
    end
    a_resp_ready = 1'b1;
    #1;
    chk("bp_rdy_on", a_req_ready, 1);
    chk("bp_vld_last", a_resp_valid, 1);
    tick();
    chk("bp_done", a_resp_valid, 0);
    chk("bp_idle", a_busy, 0);

    // Flush in WAIT with a competing request
    a_req_pc = 32'h00400000;
    a_req_valid = 1'b1;
    tick();
    chk("fl_wait", a_busy, 1);
    a_flush = 1'b1;
    a_req_pc = 32'h00400004;
    #1;
    chk("fl_rdy", a_req_ready, 0);
    tick();
    a_flush = 1'b0;
    a_req_valid = 1'b0;
    #1;
    chk("fl_busy", a_busy, 0);
    chk("fl_vld", a_resp_valid, 0);
    chk("fl_rdy_idle", a_req_ready, 1);
    tick();
    chk("fl_no_resp", a_resp_valid, 0);
    fetch_a("fl_new", 32'h00400004, 32'h34210004, 1'b0);

    // Zero wait states, back-to-back
    b_resp_ready = 1'b1;
    b_req_pc = 32'h00400000;
    b_req_valid = 1'b1;
    #1;
    chk("tp_rdy0", b_req_ready, 1);
    tick();
    b_req_pc = 32'h00400004;
    #1;
    chk("tp_vld0", b_resp_valid, 1);
    chk("tp_inst0", b_resp_inst, 32'h3C010040);
    chk("tp_pc0", b_resp_pc, 32'h00400000);
    chk("tp_rdy1", b_req_ready, 1);
    tick();
    b_req_valid = 1'b0;
    #1;
    chk("tp_vld1", b_resp_valid, 1);
    chk("tp_inst1", b_resp_inst, 32'h34210004);
    chk("tp_pc1", b_resp_pc, 32'h00400004);
    tick();
    chk("tp_done", b_resp_valid, 0);

    // Asynchronous reset while in RESP
    a_req_pc = 32'h00400000;
    a_req_valid = 1'b1;
    a_resp_ready = 1'b0;
    tick();
    a_req_valid = 1'b0;
    tick();
    chk("ar_pre_vld", a_resp_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_vld", a_resp_valid, 0);
    chk("ar_busy", a_busy, 0);
    chk("ar_inst", a_resp_inst, 0);
    chk("ar_pc", a_resp_pc, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_no_resp", a_resp_valid, 0);
    fetch_a("ar_refetch", 32'h00400000, 32'h3C010040, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
